yapp_chan_sink: RTL and testbench

- Downstream consumer of one yapp_router output channel (data_N / data_vld_N / suspend_N). One instance per channel, three in the system top.
- Parses the YAPP byte stream (header, payload, parity) and buffers payload bytes in a first-word-fall-through (FWFT) FIFO for a host-side reader.
- Reports per-packet status: address, length, parity error, address mismatch.
- Drives suspend back to the router from FIFO occupancy.

---
 rtl/yapp_chan_sink.sv | 172 +++++++++++++++++
 tb/tb_yapp_chan_sink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yapp_chan_sink.sv
// YAPP channel sink: parses header/payload/parity from one router output channel,
// buffers payload bytes in a first-word-fall-through FIFO and reports per-packet status.
module yapp_chan_sink #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned HIGH_WM   = 14,
    parameter logic [1:0]  CHAN_ADDR = 2'd0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   data,
    input  logic                         data_vld,
    output logic                         suspend,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         rd_empty,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         pkt_done,
    output logic [1:0]                   pkt_addr,
    output logic [5:0]                   pkt_len,
    output logic                         parity_err,
    output logic                         addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] HighWm = CW'(HIGH_WM);

    typedef enum logic [1:0] {StHeader, StPayload, StParity} state_e;

    state_e          state_q, state_d;
    logic [5:0]      len_q, len_d;
    logic [1:0]      addr_q, addr_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [7:0]      par_q, par_d;
    logic            done_q, done_d;
    logic [1:0]      pkt_addr_q, pkt_addr_d;
    logic [5:0]      pkt_len_q, pkt_len_d;
    logic            perr_q, perr_d;
    logic            aerr_q, aerr_d;
    logic            suspend_q, suspend_d;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            accept;
    logic            wr_en;
    logic            pop;

    assign accept = data_vld & ~suspend_q;
    assign wr_en  = accept & (state_q == StPayload);
    // Popping an empty FIFO is silently ignored.
    assign pop    = rd_en & (count_q != '0);

    // Packet parser: next state, running parity and completion status.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        done_d     = 1'b0;
        pkt_addr_d = pkt_addr_q;
        pkt_len_d  = pkt_len_q;
        perr_d     = perr_q;
        aerr_d     = aerr_q;
        unique case (state_q)
            StHeader: begin
                if (accept) begin
                    len_d   = data[7:2];
                    addr_d  = data[1:0];
                    par_d   = data;
                    cnt_d   = '0;
                    state_d = (data[7:2] != 6'd0) ? StPayload : StParity;
                end
            end
            StPayload: begin
                if (accept) begin
                    par_d = par_q ^ data;
                    cnt_d = cnt_q + 6'd1;
                    if ((cnt_q + 6'd1) == len_q) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (accept) begin
                    done_d     = 1'b1;
                    pkt_addr_d = addr_q;
                    pkt_len_d  = len_q;
                    perr_d     = (data != par_q);
                    aerr_d     = (addr_q != CHAN_ADDR);
                    state_d    = StHeader;
                end
            end
            default: state_d = StHeader;
        endcase
    end

    // FIFO pointers, occupancy and registered suspend from next-cycle occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        suspend_d = (count_d >= HighWm);
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StHeader;
            len_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            par_q      <= '0;
            done_q     <= 1'b0;
            pkt_addr_q <= '0;
            pkt_len_q  <= '0;
            perr_q     <= 1'b0;
            aerr_q     <= 1'b0;
            suspend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            done_q     <= done_d;
            pkt_addr_q <= pkt_addr_d;
            pkt_len_q  <= pkt_len_d;
            perr_q     <= perr_d;
            aerr_q     <= aerr_d;
            suspend_q  <= suspend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign suspend    = suspend_q;
    assign rd_empty   = (count_q == '0);
    assign rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign pkt_done   = done_q;
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign parity_err = perr_q;
    assign addr_err   = aerr_q;

endmodule

// File: tb/tb_yapp_chan_sink.sv
// Bench for yapp_chan_sink: two instances (CHAN_ADDR=1 and 0) share one stimulus stream
// and are compared every cycle against a queue-based packet/FIFO reference model.
module tb_yapp_chan_sink;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned HIGH_WM = 14;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    data;
    logic          data_vld;
    logic          rd_en;

    logic          susp1, empty1, done1, perr1, aerr1;
    logic [7:0]    rdata1;
    logic [CW-1:0] cnt1;
    logic [1:0]    paddr1;
    logic [5:0]    plen1;
    logic          susp0, empty0, done0, perr0, aerr0;
    logic [7:0]    rdata0;
    logic [CW-1:0] cnt0;
    logic [1:0]    paddr0;
    logic [5:0]    plen0;

    yapp_chan_sink #(.DEPTH(DEPTH), .HIGH_WM(HIGH_WM), .CHAN_ADDR(2'd1)) dut1 (
        .clock(clock), .reset(reset), .data(data), .data_vld(data_vld), .suspend(susp1),
        .rd_en(rd_en), .rd_data(rdata1), .rd_empty(empty1), .fifo_count(cnt1),
        .pkt_done(done1), .pkt_addr(paddr1), .pkt_len(plen1), .parity_err(perr1),
        .addr_err(aerr1)
    );

    yapp_chan_sink #(.DEPTH(DEPTH), .HIGH_WM(HIGH_WM), .CHAN_ADDR(2'd0)) dut0 (
        .clock(clock), .reset(reset), .data(data), .data_vld(data_vld), .suspend(susp0),
        .rd_en(rd_en), .rd_data(rdata0), .rd_empty(empty0), .fifo_count(cnt0),
        .pkt_done(done0), .pkt_addr(paddr0), .pkt_len(plen0), .parity_err(perr0),
        .addr_err(aerr0)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pkts   = 0;
    int dut_done = 0;

    // Reference model state.
    logic [7:0] mq[$];     // expected FIFO contents
    logic [7:0] pk[$];     // bytes of the packet in flight
    logic [7:0] tx_q[$];   // bytes still to be sent
    logic       exp_susp, exp_done, exp_perr, exp_aerr1, exp_aerr0, acc;
    logic [1:0] exp_addr;
    logic [5:0] exp_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock: update the model from the current inputs, then compare outputs.
    task automatic cycle();
        int plen;
        logic [7:0] x;
        if (reset) begin
            mq.delete();
            pk.delete();
            acc       = 1'b0;
            exp_susp  = 1'b0;
            exp_done  = 1'b0;
            exp_perr  = 1'b0;
            exp_aerr1 = 1'b0;
            exp_aerr0 = 1'b0;
            exp_addr  = '0;
            exp_len   = '0;
        end else begin
            acc      = data_vld && !exp_susp;
            exp_done = 1'b0;
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                pk.push_back(data);
                plen = int'(pk[0][7:2]);
                if (pk.size() > 1 && pk.size() <= plen + 1) mq.push_back(data);
                if (pk.size() == plen + 2) begin
                    x = 8'h00;
                    for (int i = 0; i <= plen; i++) x ^= pk[i];
                    exp_done  = 1'b1;
                    exp_addr  = pk[0][1:0];
                    exp_len   = pk[0][7:2];
                    exp_perr  = (x != data);
                    exp_aerr1 = (pk[0][1:0] != 2'd1);
                    exp_aerr0 = (pk[0][1:0] != 2'd0);
                    pk.delete();
                end
            end
            exp_susp = (mq.size() >= HIGH_WM);
        end
        @(posedge clock);
        #1;
        if (done1) dut_done++;
        chk("d1.suspend", 32'(susp1), 32'(exp_susp));
        chk("d1.fifo_count", 32'(cnt1), mq.size());
        chk("d1.rd_empty", 32'(empty1), 32'(mq.size() == 0));
        chk("d1.rd_data", 32'(rdata1), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        chk("d1.pkt_done", 32'(done1), 32'(exp_done));
        chk("d1.pkt_addr", 32'(paddr1), 32'(exp_addr));
        chk("d1.pkt_len", 32'(plen1), 32'(exp_len));
        chk("d1.parity_err", 32'(perr1), 32'(exp_perr));
        chk("d1.addr_err", 32'(aerr1), 32'(exp_aerr1));
        chk("d1.no_overflow", 32'(cnt1 <= DEPTH), 32'h1);
        chk("d0.suspend", 32'(susp0), 32'(exp_susp));
        chk("d0.fifo_count", 32'(cnt0), mq.size());
        chk("d0.rd_data", 32'(rdata0), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        chk("d0.pkt_done", 32'(done0), 32'(exp_done));
        chk("d0.pkt_addr", 32'(paddr0), 32'(exp_addr));
        chk("d0.pkt_len", 32'(plen0), 32'(exp_len));
        chk("d0.parity_err", 32'(perr0), 32'(exp_perr));
        chk("d0.addr_err", 32'(aerr0), 32'(exp_aerr0));
    endtask

    // Present tx_q bytes with random gaps and pops until sent or the cycle budget runs out.
    task automatic run_stream(input int gap_pct, input int pop_pct, input int budget,
                              input bit must_finish);
        int n = 0;
        while (tx_q.size() > 0 && n < budget) begin
            data     = tx_q[0];
            data_vld = ($urandom_range(99) >= gap_pct);
            rd_en    = ($urandom_range(99) < pop_pct);
            cycle();
            if (acc) void'(tx_q.pop_front());
            n++;
        end
        data_vld = 1'b0;
        rd_en    = 1'b0;
        if (must_finish) chk("stream_done", tx_q.size(), 0);
    endtask

    task automatic build_pkt(input logic [1:0] addr, input logic [5:0] len, input bit bad);
        logic [7:0] hdr;
        logic [7:0] p;
        logic [7:0] b;
        hdr = {len, addr};
        p   = hdr;
        tx_q.push_back(hdr);
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            p ^= b;
            tx_q.push_back(b);
        end
        tx_q.push_back(bad ? ~p : p);
        n_pkts++;
    endtask

    task automatic drain();
        int n = 0;
        rd_en    = 1'b1;
        data_vld = 1'b0;
        while (mq.size() > 0 && n < 4 * DEPTH) begin
            cycle();
            n++;
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(empty1), 32'h1);
    endtask

    initial begin
        reset = 1'b1; data = 8'h00; data_vld = 1'b0; rd_en = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;

        // Basic packet, back to back.
        tx_q = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0};
        n_pkts++;
        run_stream(0, 0, 20, 1'b1);
        chk("basic.done", 32'(done1), 32'h1);
        chk("basic.len", 32'(plen1), 32'd3);
        chk("basic.head", 32'(rdata1), 32'hAA);
        chk("basic.addr_err0", 32'(aerr0), 32'h1);
        drain();

        // Zero-length packet.
        tx_q = '{8'h01, 8'h01};
        n_pkts++;
        run_stream(0, 0, 10, 1'b1);
        chk("zero.len", 32'(plen1), 32'd0);
        chk("zero.count", 32'(cnt1), 32'd0);

        // Bad parity, payload still delivered.
        tx_q = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD1};
        n_pkts++;
        run_stream(0, 0, 20, 1'b1);
        chk("badpar.perr", 32'(perr1), 32'h1);
        chk("badpar.count", 32'(cnt1), 32'd3);
        drain();

        // Backpressure: 20-byte payload with no reads.
        build_pkt(2'd1, 6'd20, 1'b0);
        run_stream(0, 0, 40, 1'b0);
        chk("bp.count", 32'(cnt1), 32'd14);
        chk("bp.suspend", 32'(susp1), 32'h1);
        chk("bp.left", tx_q.size(), 32'd7);
        data = tx_q[0]; data_vld = 1'b1; rd_en = 1'b1;
        cycle();
        if (acc) void'(tx_q.pop_front());
        chk("bp.release", 32'(susp1), 32'h0);
        run_stream(0, 30, 200, 1'b1);
        drain();

        // Reset in mid-packet.
        tx_q = '{8'h0D, 8'hAA};
        run_stream(0, 0, 10, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst.count", 32'(cnt1), 32'd0);
        chk("rst.empty", 32'(empty1), 32'h1);
        tx_q = '{8'h05, 8'h11, 8'h14};
        n_pkts++;
        run_stream(0, 0, 10, 1'b1);
        chk("rst.len", 32'(plen1), 32'd1);
        chk("rst.addr", 32'(paddr1), 32'd1);
        chk("rst.perr", 32'(perr1), 32'h0);
        chk("rst.rd_data", 32'(rdata1), 32'h11);
        drain();

        // Random packets with gaps, random reads and occasional bad parity.
        for (int k = 0; k < 25; k++) begin
            build_pkt(2'($urandom_range(3)), 6'($urandom_range(24)), ($urandom_range(3) == 0));
            run_stream(30, 40, 2000, 1'b1);
        end
        drain();
        for (int i = 0; i < 3; i++) cycle();
        chk("pkt_done_count", dut_done, n_pkts);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
